// File: rtl/repairmb_sb_arbiter_pkg.sv
// Shared REPAIRMB sideband definitions: arbiter states, requester indices and
// sideband message field widths.
package repairmb_sb_arbiter_pkg;

  localparam int MSG_W  = 4;
  localparam int INFO_W = 3;

  localparam int REQ_TX = 0;
  localparam int REQ_RX = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } sb_state_e;

endpackage

// File: rtl/repairmb_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not served last. Purely combinational, one-hot result.
module repairmb_rr_pick2
  import repairmb_sb_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_rx,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req[REQ_TX] && i_req[REQ_RX]) begin
      o_gnt = '0;
      if (i_last_rx) o_gnt[REQ_TX] = 1'b1;
      else           o_gnt[REQ_RX] = 1'b1;
    end
  end

endmodule

// File: rtl/repairmb_sb_arbiter.sv
// Round-robin sequencer for the shared REPAIRMB sideband TX port: latches the
// winner's message, tracks the sideband busy window, pulses done, supervises timeout.
module repairmb_sb_arbiter
  import repairmb_sb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_req_tx,
  input  logic [MSG_W-1:0]  i_msg_tx,
  input  logic [INFO_W-1:0] i_info_tx,
  input  logic              i_req_rx,
  input  logic [MSG_W-1:0]  i_msg_rx,
  input  logic [INFO_W-1:0] i_info_rx,
  input  logic              i_sb_busy,
  input  logic              i_falling_edge_busy,
  output logic              o_grant_tx,
  output logic              o_grant_rx,
  output logic              o_done_tx,
  output logic              o_done_rx,
  output logic [MSG_W-1:0]  o_TX_SbMessage,
  output logic [INFO_W-1:0] o_msg_info,
  output logic              o_tx_data_valid,
  output logic              o_timeout
);

  // Handshake: o_tx_data_valid stays high from grant until i_sb_busy is sampled
  // high; the owner's request is not consulted again until its done pulse.
  sb_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic               r_last_rx, w_last_rx_nxt;
  logic               r_grant_tx, r_grant_rx, w_grant_tx_nxt, w_grant_rx_nxt;
  logic               r_done_tx, r_done_rx, w_done_tx_nxt, w_done_rx_nxt;
  logic [MSG_W-1:0]   r_msg, w_msg_nxt;
  logic [INFO_W-1:0]  r_info, w_info_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [1:0]         w_req, w_pick;
  logic               w_tmo_hit;

  assign w_req[REQ_TX] = i_req_tx;
  assign w_req[REQ_RX] = i_req_rx;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_tmo_hit     = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  repairmb_rr_pick2 u_pick (
    .i_req     (w_req),
    .i_last_rx (r_last_rx),
    .o_gnt     (w_pick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_rx_nxt  = r_last_rx;
    w_grant_tx_nxt = r_grant_tx;
    w_grant_rx_nxt = r_grant_rx;
    w_done_tx_nxt  = 1'b0;
    w_done_rx_nxt  = 1'b0;
    w_msg_nxt      = r_msg;
    w_info_nxt     = r_info;
    w_valid_nxt    = r_valid;
    w_timeout_nxt  = r_timeout;
    if (!i_enable) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_grant_tx_nxt = 1'b0;
      w_grant_rx_nxt = 1'b0;
      w_msg_nxt      = '0;
      w_info_nxt     = '0;
      w_valid_nxt    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((|w_req) && !i_sb_busy) begin
            w_state_nxt    = SEND;
            w_cnt_nxt      = '0;
            w_valid_nxt    = 1'b1;
            w_grant_tx_nxt = w_pick[REQ_TX];
            w_grant_rx_nxt = w_pick[REQ_RX];
            w_last_rx_nxt  = w_pick[REQ_RX];
            w_msg_nxt      = w_pick[REQ_RX] ? i_msg_rx  : i_msg_tx;
            w_info_nxt     = w_pick[REQ_RX] ? i_info_rx : i_info_tx;
          end
        end
        SEND, WAIT: begin
          w_cnt_nxt = w_cnt_inc;
          // A completion landing on the timeout cycle still counts as success.
          if (r_state == WAIT && i_falling_edge_busy) begin
            w_state_nxt    = GAP;
            w_done_tx_nxt  = r_grant_tx;
            w_done_rx_nxt  = r_grant_rx;
            w_grant_tx_nxt = 1'b0;
            w_grant_rx_nxt = 1'b0;
            w_msg_nxt      = '0;
            w_info_nxt     = '0;
          end else if (w_tmo_hit) begin
            w_state_nxt    = GAP;
            w_timeout_nxt  = 1'b1;
            w_grant_tx_nxt = 1'b0;
            w_grant_rx_nxt = 1'b0;
            w_msg_nxt      = '0;
            w_info_nxt     = '0;
            w_valid_nxt    = 1'b0;
          end else if (r_state == SEND && i_sb_busy) begin
            w_state_nxt = WAIT;
            w_valid_nxt = 1'b0;
          end
        end
        GAP:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_rx  <= 1'b1;
      r_grant_tx <= 1'b0;
      r_grant_rx <= 1'b0;
      r_done_tx  <= 1'b0;
      r_done_rx  <= 1'b0;
      r_msg      <= '0;
      r_info     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_rx  <= w_last_rx_nxt;
      r_grant_tx <= w_grant_tx_nxt;
      r_grant_rx <= w_grant_rx_nxt;
      r_done_tx  <= w_done_tx_nxt;
      r_done_rx  <= w_done_rx_nxt;
      r_msg      <= w_msg_nxt;
      r_info     <= w_info_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign o_grant_tx      = r_grant_tx;
  assign o_grant_rx      = r_grant_rx;
  assign o_done_tx       = r_done_tx;
  assign o_done_rx       = r_done_rx;
  assign o_TX_SbMessage  = r_msg;
  assign o_msg_info      = r_info;
  assign o_tx_data_valid = r_valid;
  assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_repairmb_sb_arbiter.sv
// Directed bench for repairmb_sb_arbiter: per-cycle vector table for arbitration
// and completion, plus hand sequences for timeout, abort, dropped request and tie.
module tb_repairmb_sb_arbiter;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable, i_req_tx, i_req_rx, i_sb_busy, i_falling_edge_busy;
  logic [3:0] i_msg_tx, i_msg_rx;
  logic [2:0] i_info_tx, i_info_rx;
  logic       o_grant_tx, o_grant_rx, o_done_tx, o_done_rx, o_tx_data_valid, o_timeout;
  logic [3:0] o_TX_SbMessage;
  logic [2:0] o_msg_info;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  repairmb_sb_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .i_enable            (i_enable),
    .i_req_tx            (i_req_tx),
    .i_msg_tx            (i_msg_tx),
    .i_info_tx           (i_info_tx),
    .i_req_rx            (i_req_rx),
    .i_msg_rx            (i_msg_rx),
    .i_info_rx           (i_info_rx),
    .i_sb_busy           (i_sb_busy),
    .i_falling_edge_busy (i_falling_edge_busy),
    .o_grant_tx          (o_grant_tx),
    .o_grant_rx          (o_grant_rx),
    .o_done_tx           (o_done_tx),
    .o_done_rx           (o_done_rx),
    .o_TX_SbMessage      (o_TX_SbMessage),
    .o_msg_info          (o_msg_info),
    .o_tx_data_valid     (o_tx_data_valid),
    .o_timeout           (o_timeout)
  );

  // Output word layout: {grant_tx, grant_rx, done_tx, done_rx, valid, timeout, msg[3:0], info[2:0]}
  logic [12:0] w_outs;
  assign w_outs = {o_grant_tx, o_grant_rx, o_done_tx, o_done_rx, o_tx_data_valid,
                   o_timeout, o_TX_SbMessage, o_msg_info};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] exp_q[$];

  function automatic logic [12:0] mk(input logic gtx, input logic grx, input logic dtx,
                                     input logic drx, input logic v, input logic t,
                                     input logic [3:0] m, input logic [2:0] inf);
    return {gtx, grx, dtx, drx, v, t, m, inf};
  endfunction

  task automatic check(input string name);
    logic [12:0] e;
    e = exp_q.pop_front();
    n_tests++;
    if (w_outs !== e) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (gtx grx dtx drx valid tmo msg info)", name, w_outs, e);
    end
  endtask

  task automatic expect_now(input string name, input logic [12:0] e);
    exp_q.push_back(e);
    check(name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic rtx, input logic [3:0] mtx,
                       input logic [2:0] itx, input logic rrx, input logic [3:0] mrx,
                       input logic [2:0] irx, input logic busy, input logic fall);
    i_enable = en;  i_req_tx = rtx; i_msg_tx = mtx; i_info_tx = itx;
    i_req_rx = rrx; i_msg_rx = mrx; i_info_rx = irx;
    i_sb_busy = busy; i_falling_edge_busy = fall;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    expect_now("reset_state", 13'h0);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        en;
    logic        rtx;
    logic [3:0]  mtx;
    logic [2:0]  itx;
    logic        rrx;
    logic [3:0]  mrx;
    logic [2:0]  irx;
    logic        busy;
    logic        fall;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic en, input logic rtx, input logic [3:0] mtx,
                                  input logic [2:0] itx, input logic rrx, input logic [3:0] mrx,
                                  input logic [2:0] irx, input logic busy, input logic fall,
                                  input logic [12:0] e);
    vec_t v;
    v = '{en, rtx, mtx, itx, rrx, mrx, irx, busy, fall, e};
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] g_tx_v, g_tx_w, d_tx, g_rx_v, g_rx_w, d_rx, a_v, a_w, e;

    g_tx_v = mk(1, 0, 0, 0, 1, 0, 4'h5, 3'h2);
    g_tx_w = mk(1, 0, 0, 0, 0, 0, 4'h5, 3'h2);
    g_rx_v = mk(0, 1, 0, 0, 1, 0, 4'hA, 3'h5);
    g_rx_w = mk(0, 1, 0, 0, 0, 0, 4'hA, 3'h5);
    d_tx   = mk(0, 0, 1, 0, 0, 0, 4'h0, 3'h0);
    d_rx   = mk(0, 0, 0, 1, 0, 0, 4'h0, 3'h0);
    a_v    = mk(1, 0, 0, 0, 1, 0, 4'h3, 3'h1);
    a_w    = mk(1, 0, 0, 0, 0, 0, 4'h3, 3'h1);

    // Both requests held high from reset: tx, rx, tx, rx with GAP+IDLE between.
    for (int r = 0; r < 2; r++) begin
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 0, 0, g_tx_v);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 1, 0, g_tx_w);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 0, 1, d_tx);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 0, 0, 13'h0);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 0, 0, g_rx_v);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 1, 0, g_rx_w);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 0, 1, d_rx);
      add_vec(1, 1, 4'h5, 3'h2, 1, 4'hA, 3'h5, 0, 0, 13'h0);
    end
    // Busy already high in IDLE, then enable low: no grant.
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 1, 0, 13'h0);
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 1, 0, 13'h0);
    add_vec(0, 1, 4'h3, 3'h1, 1, 4'hA, 3'h5, 0, 0, 13'h0);
    // Single tx request, busy rises two cycles after grant.
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 0, 0, a_v);
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 0, 0, a_v);
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 1, 0, a_w);
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 1, 0, a_w);
    add_vec(1, 1, 4'h3, 3'h1, 0, 4'h0, 3'h0, 0, 1, d_tx);
    add_vec(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0, 13'h0);

    do_reset();

    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].rtx, vecs[i].mtx, vecs[i].itx, vecs[i].rrx,
            vecs[i].mrx, vecs[i].irx, vecs[i].busy, vecs[i].fall);
      tick();
      check($sformatf("vec%0d", i));
    end

    // Timeout: rx granted, busy never rises.
    e = mk(0, 1, 0, 0, 1, 0, 4'h7, 3'h3);
    drive(1, 0, 4'h0, 3'h0, 1, 4'h7, 3'h3, 0, 0);
    tick(); expect_now("tmo_grant", e);
    for (int k = 1; k < 8; k++) begin
      tick(); expect_now($sformatf("tmo_hold%0d", k), e);
    end
    tick(); expect_now("tmo_fire", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("tmo_gap", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));
    tick(); expect_now("tmo_idle", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));

    // Abort during WAIT, then a normal transfer with sticky timeout still set.
    drive(1, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("abort_grant", mk(1, 0, 0, 0, 1, 1, 4'h9, 3'h4));
    drive(1, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 1, 0);
    tick(); expect_now("abort_wait", mk(1, 0, 0, 0, 0, 1, 4'h9, 3'h4));
    drive(0, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 1, 0);
    tick(); expect_now("abort_off", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));
    drive(0, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 0, 1);
    tick(); expect_now("abort_nodone", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));
    drive(1, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("reen_grant", mk(1, 0, 0, 0, 1, 1, 4'h9, 3'h4));
    drive(1, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 1, 0);
    tick(); expect_now("reen_wait", mk(1, 0, 0, 0, 0, 1, 4'h9, 3'h4));
    drive(1, 1, 4'h9, 3'h4, 0, 4'h0, 3'h0, 0, 1);
    tick(); expect_now("reen_done", mk(0, 0, 1, 0, 0, 1, 4'h0, 3'h0));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("reen_gap", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));

    // Request dropped the cycle after grant.
    drive(1, 0, 4'h0, 3'h0, 1, 4'hC, 3'h6, 0, 0);
    tick(); expect_now("drop_grant", mk(0, 1, 0, 0, 1, 1, 4'hC, 3'h6));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("drop_send", mk(0, 1, 0, 0, 1, 1, 4'hC, 3'h6));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 1, 0);
    tick(); expect_now("drop_wait", mk(0, 1, 0, 0, 0, 1, 4'hC, 3'h6));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 1);
    tick(); expect_now("drop_done", mk(0, 0, 0, 1, 0, 1, 4'h0, 3'h0));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("drop_gap", mk(0, 0, 0, 0, 0, 1, 4'h0, 3'h0));

    // Completion and timeout on the same edge: completion wins.
    do_reset();
    drive(1, 1, 4'h2, 3'h7, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("tie_grant", mk(1, 0, 0, 0, 1, 0, 4'h2, 3'h7));
    drive(1, 1, 4'h2, 3'h7, 0, 4'h0, 3'h0, 1, 0);
    for (int k = 0; k < 7; k++) begin
      tick(); expect_now($sformatf("tie_wait%0d", k), mk(1, 0, 0, 0, 0, 0, 4'h2, 3'h7));
    end
    drive(1, 1, 4'h2, 3'h7, 0, 4'h0, 3'h0, 0, 1);
    tick(); expect_now("tie_done", mk(0, 0, 1, 0, 0, 0, 4'h0, 3'h0));
    drive(1, 0, 4'h0, 3'h0, 0, 4'h0, 3'h0, 0, 0);
    tick(); expect_now("tie_gap", 13'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/repairmb_sb_arbiter.md
# repairmb_sb_arbiter

Sequencer and arbiter for the single sideband TX message port shared by the REPAIRMB transmitter-side and partner-side state machines. It replaces the fixed-priority message mux with a round-robin grant. It holds the granted message stable until the sideband link has finished sending it, then returns a one-cycle completion pulse to the winning requester. It also supervises each transfer with a timeout and sits between the two REPAIRMB state machines and the sideband TX interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles from grant to end of sideband busy before the transfer is abandoned.
- CNT_W, 10: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; one clock, all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_enable  in  1  REPAIRMB substate active; low aborts any transfer.
- i_req_tx  in  1  transmitter-side requester wants to send; held until its done pulse.
- i_msg_tx  in  4  transmitter-side sideband message code.
- i_info_tx  in  3  transmitter-side msg_info.
- i_req_rx  in  1  partner-side request.
- i_msg_rx  in  4  partner-side message code.
- i_info_rx  in  3  partner-side msg_info.
- i_sb_busy  in  1  sideband TX busy level.
- i_falling_edge_busy  in  1  one-cycle pulse when i_sb_busy falls.
- o_grant_tx / o_grant_rx  out  1  owner indication; at most one is high.
- o_done_tx / o_done_rx  out  1  one-cycle completion pulse to the owner.
- o_TX_SbMessage  out  4  latched message of the owner; 0 when idle.
- o_msg_info  out  3  latched msg_info of the owner; 0 when idle.
- o_tx_data_valid  out  1  request to the sideband TX.
- o_timeout  out  1  sticky error flag; cleared only by rst.

## Operation
- On reset, all outputs are 0, state is IDLE, and the round-robin pointer favours tx.
- **IDLE**
  - The arbiter waits until i_enable=1, at least one request is high, and i_sb_busy=0.
  - With a single request, that requester wins.
  - With both requests high, the requester not served last wins; the pointer then points to the loser.
  - On winning, the arbiter latches the winner's msg/info, sets its grant, clears the timer and moves to SEND.
- **SEND**
  - o_tx_data_valid=1; grant, message and info are held.
  - When i_sb_busy=1 is sampled, o_tx_data_valid drops next cycle and the state moves to WAIT.
- **WAIT**
  - o_tx_data_valid=0 and the grant is held.
  - On i_falling_edge_busy, the arbiter pulses the owner's done for one cycle, clears the grant, message and info, and moves to GAP.
- **GAP**
  - Lasts one cycle with no grant, then returns to IDLE. This guarantees one dead cycle between transfers.
- **Timeout**
  - The counter increments every cycle in SEND and WAIT.
  - When it reaches TIMEOUT_CYCLES, the arbiter sets o_timeout, clears grant/valid/message with no done pulse, and goes to GAP.
  - If i_falling_edge_busy arrives in the same cycle the timeout is reached, completion wins and o_timeout is not set.
- **Abort**: i_enable=0 in any state forces IDLE on the next edge with all non-sticky outputs 0 and no done pulse. The pointer is kept.
- **Request dropped after grant**: the transfer still completes from the latched values and the done pulse is still issued.
- **Request inputs changing after grant**: no effect until the next arbitration.
- **Busy already high in IDLE**: no grant is issued.

## Timing
- A request sampled high at edge N (conditions met) gives grant, valid and message high after edge N; latency is 1 cycle.
- i_sb_busy sampled high at edge M drops o_tx_data_valid after edge M.
- i_falling_edge_busy at edge K gives the done pulse during cycle K+1 only.
- The earliest re-grant is 2 cycles after the done pulse, because of GAP then IDLE.
- The back-to-back throughput bound is SEND(≥1) + WAIT(≥1) + GAP(1) + IDLE(1) cycles per message.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared REPAIRMB package:
  - state enum (IDLE, SEND, WAIT, GAP);
  - requester index constants (REQ_TX=0, REQ_RX=1);
  - the 4-bit sideband message code width;
  - the 3-bit msg_info width.
- A single flat module is natural. The round-robin picker may be split into the sub-module repairmb_rr_pick2 (two requests, last-winner pointer in, one-hot grant out, combinational).

## Test plan
- **Single tx request**: i_req_tx=1 with msg 4'h3, info 3'h1, and busy high 2 cycles after grant. Expect o_grant_tx=1, o_TX_SbMessage=3, o_tx_data_valid for exactly 2 cycles, and o_done_tx one cycle after the falling-edge pulse.
- **Simultaneous requests from reset**: both requests high. Expect tx served first and rx second, with exactly 1 GAP + 1 IDLE cycle between o_done_tx and o_grant_rx. Repeat both requests: tx, then rx again.
- **Timeout**: TIMEOUT_CYCLES=8 and busy never rises. Expect o_timeout=1 after 8 cycles in SEND, no done pulse, and the grant cleared. o_timeout stays 1 through later successful transfers.
- **Abort**: drop i_enable during WAIT. Expect all outputs 0 next cycle and no done pulse. A new request after re-enable is granted normally.
- **Request dropped in SEND**: i_req_rx falls the cycle after grant. Expect the message to stay latched and o_done_rx to still pulse.
- **Completion vs. timeout tie**: falling edge and timeout in the same cycle. Expect the done pulse and o_timeout to stay 0.
